custom_tag_way_array: RTL

Parametrised N-way set-associative tag store for the custom CPU caches, generalising the single-way tag array to multiple ways. It holds a tag and valid bit per (set, way), performs a same-cycle tag lookup with hit and way outputs, and keeps per-set replacement state that selects a victim way. A small controller clears all valid bits set-by-set after reset and on a flush request. It sits between the I/D cache control FSMs and their data arrays.

---
 rtl/custom_tag_way_array_pkg.sv | 52 +++++
 rtl/custom_tag_way_array_if.sv | 34 +++
 rtl/custom_plru_tree.sv | 17 +
 rtl/custom_tag_way_array.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/custom_tag_way_array_pkg.sv
// rtl/custom_tag_way_array_pkg.sv - shared types and PLRU tree helpers for the N-way tag store
package custom_tag_way_array_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  localparam int PLRU_MAX_LEVELS = 3;

  function automatic int calc_way_bits(input int way_num);
    return $clog2(way_num);
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right); bit 1 points the victim right.
  function automatic logic [6:0] plru_touch(input logic [6:0] bits, input logic [2:0] way,
                                            input int levels);
    logic [6:0] r;
    logic [2:0] nd;
    logic [1:0] bi;
    logic       dir;
    r  = bits;
    nd = '0;
    for (int lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        bi    = 2'(levels - 1 - lvl);
        dir   = way[bi];
        r[nd] = ~dir;
        nd    = 3'(2 * int'(nd) + 1 + int'(dir));
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int levels);
    logic [2:0] w;
    logic [2:0] nd;
    logic       dir;
    w  = '0;
    nd = '0;
    for (int lvl = 0; lvl < PLRU_MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        dir = bits[nd];
        w   = {w[1:0], dir};
        nd  = 3'(2 * int'(nd) + 1 + int'(dir));
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/custom_tag_way_array_if.sv
// rtl/custom_tag_way_array_if.sv - lookup/fill/invalidate/flush bundle between cache FSM and tag store
interface custom_tag_way_array_if #(
  parameter int TAG_WIDTH = 24,
  parameter int SET_BITS  = 3,
  parameter int WAY_BITS  = 2
);
  logic                 flush_req;
  logic                 busy;
  logic                 lkup_valid;
  logic [SET_BITS-1:0]  lkup_set;
  logic [TAG_WIDTH-1:0] lkup_tag;
  logic                 lkup_hit;
  logic [WAY_BITS-1:0]  lkup_way;
  logic [WAY_BITS-1:0]  victim_way;
  logic                 fill_en;
  logic [SET_BITS-1:0]  fill_set;
  logic [WAY_BITS-1:0]  fill_way;
  logic [TAG_WIDTH-1:0] fill_tag;
  logic                 inv_en;
  logic [SET_BITS-1:0]  inv_set;
  logic [WAY_BITS-1:0]  inv_way;

  modport master (
    output flush_req, lkup_valid, lkup_set, lkup_tag,
    output fill_en, fill_set, fill_way, fill_tag, inv_en, inv_set, inv_way,
    input  busy, lkup_hit, lkup_way, victim_way
  );

  modport slave (
    input  flush_req, lkup_valid, lkup_set, lkup_tag,
    input  fill_en, fill_set, fill_way, fill_tag, inv_en, inv_set, inv_way,
    output busy, lkup_hit, lkup_way, victim_way
  );
endinterface

// File: rtl/custom_plru_tree.sv
// rtl/custom_plru_tree.sv - per-set tree pseudo-LRU: next bits for a touched way and current victim
module custom_plru_tree
  import custom_tag_way_array_pkg::*;
#(
  parameter int WAY_NUM  = 4,
  parameter int WAY_BITS = 2
) (
  input  logic [WAY_NUM-2:0]  bits,
  input  logic [WAY_BITS-1:0] way,
  output logic [WAY_NUM-2:0]  next_bits,
  output logic [WAY_BITS-1:0] victim
);
  localparam int NODES = WAY_NUM - 1;

  assign next_bits = NODES'(plru_touch(7'(bits), 3'(way), WAY_BITS));
  assign victim    = WAY_BITS'(plru_victim(7'(bits), WAY_BITS));
endmodule

// File: rtl/custom_tag_way_array.sv
// rtl/custom_tag_way_array.sv - N-way set-associative tag store with sweep controller
// TAG_ARRAY_PLRU_EN selects tree pseudo-LRU; otherwise a global round-robin counter.
module custom_tag_way_array
  import custom_tag_way_array_pkg::*;
#(
  parameter int TAG_WIDTH = 24,
  parameter int SET_BITS  = 3,
  parameter int WAY_NUM   = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  custom_tag_way_array_if.slave bus
);
  localparam int WAY_BITS = calc_way_bits(WAY_NUM);
  localparam int SETS     = 1 << SET_BITS;

  ctrl_state_e          state_q, state_d;
  logic [SET_BITS-1:0]  cnt_q, cnt_d;
  logic                 busy;
  logic                 fill_q, inv_q;
  logic [TAG_WIDTH-1:0] tag_q   [SETS][WAY_NUM];
  logic [WAY_NUM-1:0]   valid_q [SETS];
  logic [WAY_NUM-1:0]   match;
  logic [WAY_BITS-1:0]  hit_way, inv_low, policy_way;
  logic                 any_invalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT, ST_FLUSH: begin
        cnt_d = cnt_q + SET_BITS'(1);
        if (cnt_q == {SET_BITS{1'b1}}) state_d = ST_IDLE;
      end
      default: begin
        if (bus.flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign bus.busy = busy;
  assign fill_q   = bus.fill_en && !busy;
  assign inv_q    = bus.inv_en && !busy;

  always_comb begin
    match       = '0;
    hit_way     = '0;
    inv_low     = '0;
    any_invalid = 1'b0;
    for (int w = 0; w < WAY_NUM; w++) begin
      match[w] = valid_q[bus.lkup_set][w] && (tag_q[bus.lkup_set][w] == bus.lkup_tag);
    end
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_BITS'(w);
      if (!valid_q[bus.lkup_set][w]) begin
        inv_low     = WAY_BITS'(w);
        any_invalid = 1'b1;
      end
    end
  end

  assign bus.lkup_hit   = bus.lkup_valid && !busy && (|match);
  assign bus.lkup_way   = bus.lkup_hit ? hit_way : '0;
  assign bus.victim_way = any_invalid ? inv_low : policy_way;

  // Tags are never cleared; only the valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill_q) tag_q[bus.fill_set][bus.fill_way] <= bus.fill_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (busy) begin
      valid_q[cnt_q] <= '0;
    end else begin
      if (fill_q) valid_q[bus.fill_set][bus.fill_way] <= 1'b1;
      if (inv_q) valid_q[bus.inv_set][bus.inv_way] <= 1'b0;
    end
  end

`ifdef TAG_ARRAY_PLRU_EN
  logic [WAY_NUM-2:0]  plru_q     [SETS];
  logic [WAY_NUM-2:0]  plru_next  [SETS];
  logic [WAY_BITS-1:0] set_victim [SETS];

  // A fill to the set being hit in the same cycle overrides the hit's touch.
  for (genvar s = 0; s < SETS; s++) begin : g_plru
    logic [WAY_BITS-1:0] touch_way;
    assign touch_way = (fill_q && bus.fill_set == SET_BITS'(s)) ? bus.fill_way : bus.lkup_way;
    custom_plru_tree #(.WAY_NUM(WAY_NUM), .WAY_BITS(WAY_BITS)) u_tree (
      .bits      (plru_q[s]),
      .way       (touch_way),
      .next_bits (plru_next[s]),
      .victim    (set_victim[s])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (busy) begin
      plru_q[cnt_q] <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        if ((fill_q && bus.fill_set == SET_BITS'(s)) ||
            (bus.lkup_hit && bus.lkup_set == SET_BITS'(s)))
          plru_q[s] <= plru_next[s];
      end
    end
  end

  assign policy_way = set_victim[bus.lkup_set];
`else
  logic [WAY_BITS-1:0] rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_q <= '0;
    else if (busy)   rr_q <= '0;
    else if (fill_q) rr_q <= rr_q + WAY_BITS'(1);
  end

  assign policy_way = rr_q;
`endif

endmodule
